// File: rtl/ledpanel_pkg.sv
// Shared types and constants for the ledpanel write-port arbiter and its clear engine.
package ledpanel_pkg;

  localparam logic [3:0] WR_RGB = 4'b0111;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_FILL = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

  // Each panel holds 64x64 pixels.
  function automatic int mem_words(input int chained);
    return chained * 4096;
  endfunction

endpackage

// File: rtl/ledpanel_wr_arbiter_if.sv
// Requester A/B write channels plus the registered write port toward ledpanel.
interface ledpanel_wr_arbiter_if #(
  parameter int ADDR_W = 16
);
  // Handshake: a write moves when valid & ready in the same cycle. ready is
  // combinational and may depend on valid; valid must never depend on ready,
  // and valid plus payload stay stable until accepted.
  logic              a_valid;
  logic              a_ready;
  logic [3:0]        a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [23:0]       a_wdat;

  logic              b_valid;
  logic              b_ready;
  logic [3:0]        b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [23:0]       b_wdat;

  logic              ctrl_en;
  logic [3:0]        ctrl_wr;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [23:0]       ctrl_wdat;

  modport master (
    output a_valid, a_wr, a_addr, a_wdat,
    output b_valid, b_wr, b_addr, b_wdat,
    input  a_ready, b_ready,
    input  ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
  );

  modport slave (
    input  a_valid, a_wr, a_addr, a_wdat,
    input  b_valid, b_wr, b_addr, b_wdat,
    output a_ready, b_ready,
    output ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
  );

endinterface

// File: rtl/ledpanel_clear_engine.sv
// Frame-clear engine: floods every video-memory word with one latched colour.
module ledpanel_clear_engine
  import ledpanel_pkg::*;
#(
  parameter int CHAINED = 2,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic [23:0]       clr_color,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [23:0]       fill_wdat,
  output logic              clr_busy,
  output logic              clr_done,
  output clr_state_t        state
);

  localparam int MEM_WORDS = mem_words(CHAINED);
  localparam int CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WORDS - 1);

  clr_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      color_q, color_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d = CLR_FILL;
          cnt_d   = '0;
          color_d = clr_color;
        end
      end
      CLR_FILL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = CLR_DONE;
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  // fill_* is the word for the next cycle: the top registers it, so while in
  // FILL the word on ctrl_addr is always cnt_q.
  always_comb begin
    fill_en   = 1'b0;
    fill_addr = '0;
    fill_wdat = color_q;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          fill_en   = 1'b1;
          fill_wdat = clr_color;
        end
      end
      CLR_FILL: begin
        clr_busy = 1'b1;
        if (cnt_q != LAST) begin
          fill_en   = 1'b1;
          fill_addr = ADDR_W'(cnt_q + CNT_W'(1));
        end
      end
      CLR_DONE: clr_done = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/ledpanel_wr_arbiter.sv
// Round-robin owner of the ledpanel write port shared by requesters A, B and the clear engine.
module ledpanel_wr_arbiter
  import ledpanel_pkg::*;
#(
  parameter int CHAINED = 2,
  parameter int ADDR_W  = 16
) (
  input  logic                  ctrl_clk,
  input  logic                  reset,
  ledpanel_wr_arbiter_if.slave  bus,
  input  logic                  clr_start,
  input  logic [23:0]           clr_color,
  output logic                  clr_busy,
  output logic                  clr_done,
  output clr_state_t            clr_state
);

  logic              fill_en;
  logic [ADDR_W-1:0] fill_addr;
  logic [23:0]       fill_wdat;
  logic              blk;
  logic              a_xfer, b_xfer;
  rr_t               rr_q;

  logic              en_q;
  logic [3:0]        wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       wdat_q;

  ledpanel_clear_engine #(
    .CHAINED (CHAINED),
    .ADDR_W  (ADDR_W)
  ) u_clear (
    .clk       (ctrl_clk),
    .rst       (reset),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .fill_en   (fill_en),
    .fill_addr (fill_addr),
    .fill_wdat (fill_wdat),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .state     (clr_state)
  );

  // A clear starting this cycle already owns the next port slot.
  assign blk = clr_busy | (clr_start & (clr_state == CLR_IDLE));

  assign bus.a_ready = bus.a_valid & ~blk & (~bus.b_valid | (rr_q == RR_B));
  assign bus.b_ready = bus.b_valid & ~blk & (~bus.a_valid | (rr_q == RR_A));
  assign a_xfer      = bus.a_ready;
  assign b_xfer      = bus.b_ready;

  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      wr_q   <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      rr_q   <= RR_B;
    end else begin
      en_q <= fill_en | a_xfer | b_xfer;
      if (fill_en) begin
        wr_q   <= WR_RGB;
        addr_q <= fill_addr;
        wdat_q <= fill_wdat;
      end else if (a_xfer) begin
        wr_q   <= bus.a_wr;
        addr_q <= bus.a_addr;
        wdat_q <= bus.a_wdat;
      end else if (b_xfer) begin
        wr_q   <= bus.b_wr;
        addr_q <= bus.b_addr;
        wdat_q <= bus.b_wdat;
      end
      if (a_xfer)      rr_q <= RR_A;
      else if (b_xfer) rr_q <= RR_B;
    end
  end

  assign bus.ctrl_en   = en_q;
  assign bus.ctrl_wr   = wr_q;
  assign bus.ctrl_addr = addr_q;
  assign bus.ctrl_wdat = wdat_q;

endmodule

// File: tb/tb_ledpanel_wr_arbiter.sv
// Bench for ledpanel_wr_arbiter: directed clears/grants plus random traffic against a timeline model.
module tb_ledpanel_wr_arbiter;
  import ledpanel_pkg::*;

  localparam int MW = mem_words(2);
  localparam int W  = 44;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_start;
  logic [23:0] clr_color;
  logic        clr_busy;
  logic        clr_done;
  clr_state_t  clr_state;

  always #5 clk = ~clk;

  ledpanel_wr_arbiter_if bus ();

  ledpanel_wr_arbiter #(
    .CHAINED (2),
    .ADDR_W  (16)
  ) dut (
    .ctrl_clk  (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .clr_state (clr_state)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] exp_q[$];

  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_last_a = 0;
  int          m_pos = 0;
  logic [23:0] m_col = '0;

  bit          a_pend = 0, b_pend = 0;
  logic [3:0]  a_wr_d = '0, b_wr_d = '0;
  logic [15:0] a_addr_d = '0, b_addr_d = '0;
  logic [23:0] a_wdat_d = '0, b_wdat_d = '0;
  bit          rst_drv = 1, clr_go = 0, rand_en = 0;
  logic [23:0] clr_col_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic post_a(input logic [3:0] wr, input logic [15:0] addr, input logic [23:0] wdat);
    a_pend = 1; a_wr_d = wr; a_addr_d = addr; a_wdat_d = wdat;
  endtask

  task automatic post_b(input logic [3:0] wr, input logic [15:0] addr, input logic [23:0] wdat);
    b_pend = 1; b_wr_d = wr; b_addr_d = addr; b_wdat_d = wdat;
  endtask

  task automatic start_clear(input logic [23:0] col);
    clr_go = 1; clr_col_d = col;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check readies, advance model.
  task automatic step();
    logic [W-1:0] w;
    bit idle, start_acc, blk, a_rdy, b_rdy;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("ctrl_en", bus.ctrl_en, 1);
      chk("ctrl_wr", bus.ctrl_wr, w[43:40]);
      chk("ctrl_addr", bus.ctrl_addr, w[39:24]);
      chk("ctrl_wdat", bus.ctrl_wdat, w[23:0]);
    end else begin
      chk("ctrl_en_quiet", bus.ctrl_en, 0);
    end
    chk("clr_busy", clr_busy, m_busy);
    chk("clr_done", clr_done, m_done);

    if (rand_en) begin
      if (!a_pend && $urandom_range(0, 3) != 0)
        post_a(4'($urandom_range(0, 15)), 16'($urandom), 24'($urandom));
      if (!b_pend && $urandom_range(0, 3) != 0)
        post_b(4'($urandom_range(0, 15)), 16'($urandom), 24'($urandom));
      rst_drv = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2999) == 0) start_clear(24'($urandom));
      else if ($urandom_range(0, 199) == 0) start_clear(24'hFFFFFF);
    end

    reset       = rst_drv;
    clr_start   = clr_go;
    clr_color   = clr_col_d;
    bus.a_valid = a_pend; bus.a_wr = a_wr_d; bus.a_addr = a_addr_d; bus.a_wdat = a_wdat_d;
    bus.b_valid = b_pend; bus.b_wr = b_wr_d; bus.b_addr = b_addr_d; bus.b_wdat = b_wdat_d;
    #1;

    idle      = !m_busy && !m_done;
    start_acc = clr_go && idle && !rst_drv;
    blk       = m_busy || (clr_go && idle);
    a_rdy     = a_pend && !blk && (!b_pend || !m_last_a);
    b_rdy     = b_pend && !blk && (!a_pend || m_last_a);
    if (!rst_drv) begin
      chk("a_ready", bus.a_ready, a_rdy);
      chk("b_ready", bus.b_ready, b_rdy);
    end

    if (rst_drv) begin
      m_busy = 0; m_done = 0; m_last_a = 0;
    end else if (start_acc) begin
      m_pos = 0; m_col = clr_col_d; m_busy = 1; m_done = 0;
      exp_q.push_back({WR_RGB, 16'(m_pos), m_col});
    end else if (m_busy) begin
      if (m_pos == MW - 1) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_pos++;
        exp_q.push_back({WR_RGB, 16'(m_pos), m_col});
      end
    end else begin
      m_done = 0;
      if (a_rdy) begin
        exp_q.push_back({a_wr_d, a_addr_d, a_wdat_d});
        m_last_a = 1; a_pend = 0;
      end else if (b_rdy) begin
        exp_q.push_back({b_wr_d, b_addr_d, b_wdat_d});
        m_last_a = 0; b_pend = 0;
      end
    end
    clr_go = 0;
  endtask

  initial begin
    reset = 1; clr_start = 0; clr_color = '0;
    bus.a_valid = 0; bus.a_wr = '0; bus.a_addr = '0; bus.a_wdat = '0;
    bus.b_valid = 0; bus.b_wr = '0; bus.b_addr = '0; bus.b_wdat = '0;
    repeat (3) @(posedge clk);
    step();
    chk("rst_ctrl_wr", bus.ctrl_wr, 0);
    chk("rst_ctrl_addr", bus.ctrl_addr, 0);
    chk("rst_ctrl_wdat", bus.ctrl_wdat, 0);
    chk("rst_clr_state", clr_state, CLR_IDLE);
    rst_drv = 0;
    step();

    // Lone A write, then both requesters contending.
    post_a(4'b0100, 16'h0010, 24'h3F0000);
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      if (!a_pend) post_a(4'($urandom_range(0, 15)), 16'($urandom), 24'($urandom));
      if (!b_pend) post_b(4'($urandom_range(0, 15)), 16'($urandom), 24'($urandom));
      step();
    end
    repeat (4) step();

    // Full clear; a restart pulse in the DONE cycle must be ignored.
    start_clear(24'h010203);
    step();
    repeat (MW) step();
    start_clear(24'hABCDEF);
    step();
    repeat (3) step();

    // B held across a clear, with A's request landing on the start cycle.
    post_b(4'b0011, 16'h1234, 24'h00FF00);
    post_a(4'b0001, 16'h0042, 24'h0000AA);
    start_clear(24'h202020);
    step();
    repeat (MW + 4) step();

    // Restart attempt at fill address 100.
    start_clear(24'h0A0B0C);
    step();
    repeat (100) step();
    start_clear(24'h777777);
    step();
    repeat (MW) step();

    // Reset at fill address 500, then a fresh clear.
    start_clear(24'h555555);
    step();
    repeat (500) step();
    rst_drv = 1;
    step();
    rst_drv = 0;
    repeat (4) step();
    start_clear(24'h123456);
    step();
    repeat (MW + 2) step();

    rand_en = 1;
    repeat (3000) step();
    rand_en = 0;
    rst_drv = 0;
    for (int i = 0; i < 20000 && (m_busy || m_done || a_pend || b_pend); i++) step();
    chk("drain_idle", {m_busy, m_done, a_pend, b_pend}, 0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
